// File: rtl/lc3_reg_file.sv
// LC-3 general-purpose register file with NZP condition codes
// and a per-register busy scoreboard for the pipelined decoder.
module lc3_reg_file #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                cc_en,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    output logic [WIDTH-1:0]    rd_data_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [WIDTH-1:0]    rd_data_b,
    input  logic                claim_en,
    input  logic [ADDR_W-1:0]   claim_addr,
    output logic                busy_a,
    output logic                busy_b,
    output logic [2:0]          nzp,
    output logic [NUM_REGS-1:0] busy_vec
);

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [2:0]          nzp_q;
    logic [2:0]          nzp_d;
    logic                fwd_a;
    logic                fwd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        nzp_d = nzp_q;
        if (wr_en && cc_en) begin
            if (wr_data[WIDTH-1]) begin
                nzp_d = CC_N;
            end else if (wr_data == '0) begin
                nzp_d = CC_Z;
            end else begin
                nzp_d = CC_P;
            end
        end
    end

    // Claim is applied after release so a same-index claim wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (claim_en) begin
            busy_d[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzp_q  <= CC_Z;
            busy_q <= '0;
        end else begin
            nzp_q  <= nzp_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        fwd_a = BYPASS && wr_en && (wr_addr == rd_addr_a);
        fwd_b = BYPASS && wr_en && (wr_addr == rd_addr_b);
    end

    always_comb begin
        rd_data_a = fwd_a ? wr_data : regs_q[rd_addr_a];
        rd_data_b = fwd_b ? wr_data : regs_q[rd_addr_b];
        busy_a    = fwd_a ? 1'b0 : busy_q[rd_addr_a];
        busy_b    = fwd_b ? 1'b0 : busy_q[rd_addr_b];
    end

    assign nzp      = nzp_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_lc3_reg_file.sv
// Randomized self-checking bench for lc3_reg_file, comparing a
// bypassing and a non-bypassing instance against one array model.
module tb_lc3_reg_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        cc_en = 1'b0;
    logic [2:0]  rd_addr_a = '0;
    logic [2:0]  rd_addr_b = '0;
    logic        claim_en = 1'b0;
    logic [2:0]  claim_addr = '0;

    logic [15:0] rd_a1, rd_b1, rd_a0, rd_b0;
    logic        bz_a1, bz_b1, bz_a0, bz_b0;
    logic [2:0]  nzp1, nzp0;
    logic [7:0]  bv1, bv0;

    int total = 0;
    int bad = 0;

    logic [15:0] m_regs [8];
    logic [7:0]  m_busy;
    logic [2:0]  m_nzp;

    always #5 clk = ~clk;

    lc3_reg_file #(.BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cc_en(cc_en),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_a1),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_b1),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .busy_a(bz_a1), .busy_b(bz_b1),
        .nzp(nzp1), .busy_vec(bv1)
    );

    lc3_reg_file #(.BYPASS(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cc_en(cc_en),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_a0),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_b0),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .busy_a(bz_a0), .busy_b(bz_b0),
        .nzp(nzp0), .busy_vec(bv0)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] cc_of(input logic [15:0] d);
        if ($signed(d) < 0) return 3'b100;
        if (d == 16'd0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 16'h0000;
        m_busy = 8'h00;
        m_nzp  = 3'b010;
    endtask

    task automatic drive(input logic we, input logic [2:0] wa,
                         input logic [15:0] wd, input logic ce,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input logic cl, input logic [2:0] ca);
        wr_en = we; wr_addr = wa; wr_data = wd; cc_en = ce;
        rd_addr_a = ra; rd_addr_b = rb;
        claim_en = cl; claim_addr = ca;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".nzp"}, 32'(nzp1), 32'(m_nzp));
        chk({tag, ".nzp0"}, 32'(nzp0), 32'(m_nzp));
        chk({tag, ".bvec"}, 32'(bv1), 32'(m_busy));
        chk({tag, ".bvec0"}, 32'(bv0), 32'(m_busy));
    endtask

    // Compare the combinational view mid-cycle, then commit the edge.
    task automatic cyc(input string tag);
        logic hit_a, hit_b;
        @(negedge clk);
        hit_a = wr_en && (wr_addr == rd_addr_a);
        hit_b = wr_en && (wr_addr == rd_addr_b);
        chk({tag, ".rda"}, 32'(rd_a1),
            32'(hit_a ? wr_data : m_regs[rd_addr_a]));
        chk({tag, ".rdb"}, 32'(rd_b1),
            32'(hit_b ? wr_data : m_regs[rd_addr_b]));
        chk({tag, ".bza"}, 32'(bz_a1),
            32'(hit_a ? 1'b0 : m_busy[rd_addr_a]));
        chk({tag, ".bzb"}, 32'(bz_b1),
            32'(hit_b ? 1'b0 : m_busy[rd_addr_b]));
        chk({tag, ".rda0"}, 32'(rd_a0), 32'(m_regs[rd_addr_a]));
        chk({tag, ".rdb0"}, 32'(rd_b0), 32'(m_regs[rd_addr_b]));
        chk({tag, ".bza0"}, 32'(bz_a0), 32'(m_busy[rd_addr_a]));
        chk({tag, ".bzb0"}, 32'(bz_b0), 32'(m_busy[rd_addr_b]));
        chk_state(tag);
        @(posedge clk);
        if (wr_en) begin
            m_regs[wr_addr] = wr_data;
            if (cc_en) m_nzp = cc_of(wr_data);
            m_busy[wr_addr] = 1'b0;
        end
        if (claim_en) m_busy[claim_addr] = 1'b1;
        #1;
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 chk_state("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 3'(i), 3'(i), 0, 0);
            cyc("rdall");
        end

        drive(1, 3, 16'h1234, 0, 3, 0, 0, 0);
        cyc("wr3");
        drive(0, 0, 0, 0, 3, 3, 0, 0);
        cyc("rd3");

        drive(1, 1, 16'h8001, 1, 1, 2, 0, 0);
        cyc("ccN");
        drive(1, 1, 16'h0000, 1, 1, 2, 0, 0);
        cyc("ccZ");
        drive(1, 2, 16'h0005, 1, 1, 2, 0, 0);
        cyc("ccP");
        drive(1, 4, 16'hFFFF, 0, 4, 2, 0, 0);
        cyc("ccOff");
        drive(0, 4, 16'h8000, 1, 4, 2, 0, 0);
        cyc("ccNoWr");

        drive(0, 0, 0, 0, 5, 5, 1, 5);
        cyc("clm5");
        drive(0, 0, 0, 0, 5, 0, 0, 0);
        cyc("bsy5");
        drive(1, 5, 16'h5A5A, 0, 5, 5, 0, 0);
        cyc("wb5");
        drive(0, 0, 0, 0, 5, 5, 0, 0);
        cyc("aft5");

        drive(0, 0, 0, 0, 2, 2, 1, 2);
        cyc("clm2");
        drive(1, 2, 16'hC0DE, 0, 2, 1, 1, 2);
        cyc("both2");
        drive(1, 4, 16'h0444, 0, 1, 4, 1, 1);
        cyc("cl1wr4");
        drive(0, 0, 0, 0, 2, 4, 1, 1);
        cyc("aftBoth");

        drive(1, 7, 16'hBEEF, 1, 7, 6, 1, 6);
        cyc("pre6");
        drive(0, 0, 0, 0, 7, 6, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_state("arst");
        chk("arst.r7", 32'(rd_a1), 32'h0);
        chk("arst.bz6", 32'(bz_b1), 32'h0);
        drive(1, 6, 16'h1234, 1, 7, 6, 1, 3);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 7, 6, 0, 0);
        #1 chk_state("rstWr");
        chk("rstWr.r6", 32'(rd_b1), 32'h0);
        chk("rstWr.r6n", 32'(rd_b0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 7, 6, 0, 0);
        cyc("postRst");

        for (int n = 0; n < 400; n++) begin
            logic [15:0] d;
            case ($urandom_range(0, 5))
                0: d = 16'h0000;
                1: d = 16'h8000;
                2: d = 16'h7FFF;
                default: d = 16'($urandom);
            endcase
            drive(1'($urandom), 3'($urandom), d, 1'($urandom),
                  3'($urandom), 3'($urandom),
                  1'($urandom), 3'($urandom));
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc3_reg_file.md
Name: lc3_reg_file

Overview:
Parametrised general-purpose register file for the LC-3 datapath, generalising the single 16-bit register to NUM_REGS entries of WIDTH bits. Provides two asynchronous read ports, one synchronous write port, an optional write-to-read bypass, the NZP condition-code register, and a per-register busy scoreboard for the pipelined decode stage. Sits between decode (read and claim) and writeback (write and release).

Parameters:
WIDTH, 16, data width of each register (≥2)
NUM_REGS, 8, number of registers; power of two, ≥2
ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden)
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the stored value only

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write register index
wr_data  in  WIDTH  write data
cc_en  in  1  update NZP from wr_data; qualified by wr_en
rd_addr_a  in  ADDR_W  read port A index
rd_data_a  out  WIDTH  read port A data
rd_addr_b  in  ADDR_W  read port B index
rd_data_b  out  WIDTH  read port B data
claim_en  in  1  mark claim_addr busy (instruction issued with that destination)
claim_addr  in  ADDR_W  register to claim
busy_a  out  1  source A is pending
busy_b  out  1  source B is pending
nzp  out  3  condition codes {N,Z,P}
busy_vec  out  NUM_REGS  raw scoreboard bits, for debug

Behaviour:
- Reset: asynchronous and active-low; asserting rst_n low immediately clears all registers to 0, clears busy_vec to 0, and sets nzp=3'b010. Reset mid-write discards the write. State is held while rst_n is low; normal operation resumes on the first posedge after deassertion.
- Write: on posedge, if wr_en, regs[wr_addr] <= wr_data. Write latency is 1 cycle.
- Read: combinational. rd_data_x = regs[rd_addr_x].
  - If BYPASS=1 and wr_en and wr_addr==rd_addr_x, rd_data_x = wr_data in the same cycle.
  - Both ports may address the same register, including the write target.
- NZP: on posedge, if wr_en && cc_en, nzp is set from wr_data:
  - 3'b100 if wr_data[WIDTH-1]=1;
  - otherwise 3'b010 if wr_data==0;
  - otherwise 3'b001.
  - Exactly one bit is set at all times. cc_en without wr_en is ignored.
- Scoreboard: on posedge:
  - a write clears busy_vec[wr_addr];
  - a claim sets busy_vec[claim_addr];
  - if both target the same index in the same cycle, the claim wins and the bit ends at 1;
  - a claim of an already-busy register keeps it at 1 (no counting);
  - a write to a non-busy register is legal and leaves the bit at 0.
- busy_x: busy_vec[rd_addr_x], except that when BYPASS=1 and wr_en and wr_addr==rd_addr_x, busy_x=0, because the value is being forwarded this cycle.
- No internal stall logic; decode consumes busy_a/busy_b.
- All indices are in range by construction (NUM_REGS is a power of two); there is no out-of-range case.

Test Plan:
1. Reset then read all: rst_n low, then high; read R0..R7 on both ports -> every rd_data=16'h0000, nzp=3'b010, busy_vec=8'h00.
2. Write then read: write R3=16'h1234 at cycle t; read R3 on port A at t+1 -> 16'h1234. With BYPASS=1, rd_addr_a=3 during cycle t -> 16'h1234 in the same cycle. With BYPASS=0 -> old value 16'h0000.
3. NZP: write 16'h8001 with cc_en -> nzp=100; write 16'h0000 with cc_en -> 010; write 16'h0005 with cc_en -> 001; write 16'hFFFF with cc_en=0 -> nzp remains 001.
4. Scoreboard: claim R5 -> busy_vec[5]=1 and busy_a=1 for rd_addr_a=5. In the writeback cycle (wr_addr=5, BYPASS=1), busy_a=0 and rd_data_a=wr_data; after the posedge, busy_vec[5]=0.
5. Simultaneous claim and write on R2 with busy_vec[2]=1 -> busy_vec[2]=1 after the edge and the register holds the new data. Same cycle, claim R1 with write R4 -> busy_vec[1]=1, busy_vec[4]=0.
6. Async reset mid-operation: after writing R7=16'hBEEF, claiming R6 and setting nzp=100, pull rst_n low between clock edges -> immediately R7=0, busy_vec=0, nzp=010. A wr_en that is active on the next edge while reset is low has no effect.
